// File: rtl/sccb_init_sequencer_if.sv
// SCCB transaction-engine handshake bundle.
// The sequencer (master) drives a request plus device/register/data payload;
// the engine (slave) answers with a one-cycle done pulse and a NACK flag.
interface sccb_init_sequencer_if;
  logic       eng_req;
  logic [7:0] eng_dev;
  logic [7:0] eng_reg;
  logic [7:0] eng_dat;
  logic       eng_done;
  logic       eng_nack;

  modport master (
    output eng_req, eng_dev, eng_reg, eng_dat,
    input  eng_done, eng_nack
  );

  modport slave (
    input  eng_req, eng_dev, eng_reg, eng_dat,
    output eng_done, eng_nack
  );
endinterface

// File: rtl/sccb_init_sequencer.sv
// OV7670 SCCB init sequencer.
// Walks a register table from a synchronous ROM and issues one SCCB write per
// entry. A settle delay follows any COM7 soft-reset write (reg 0x12, bit 7).
// After the walk completes, the engine is lent to a runtime write port.
// Optional feature: define SCCB_RETRY_EN to re-issue NACKed writes up to
// MAX_RETRY extra times; without it the first NACK is final.
module sccb_init_sequencer #(
  parameter int         NUM_REGS       = 5,
  parameter int         TBL_AW         = 4,
  parameter logic [7:0] DEV_ADDR       = 8'h42,
  parameter int         RESET_WAIT_CYC = 50000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  output logic [TBL_AW-1:0]     tbl_addr_o,
  input  logic [15:0]           tbl_data_i,
  sccb_init_sequencer_if.master eng,
  input  logic                  usr_req_i,
  input  logic [7:0]            usr_reg_i,
  input  logic [7:0]            usr_dat_i,
  output logic                  usr_gnt_o,
  output logic                  usr_done_o,
  output logic                  usr_err_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [TBL_AW-1:0]     err_index_o
);

`ifdef SCCB_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int SETTLE_W = (RESET_WAIT_CYC > 1) ? $clog2(RESET_WAIT_CYC) : 1;
  localparam int RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TBL_AW-1:0]   LAST_IDX    = TBL_AW'(NUM_REGS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(RESET_WAIT_CYC - 1);
  localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam bit                  HAS_SETTLE  = (RESET_WAIT_CYC > 0);

  typedef enum logic [2:0] {
    S_FETCH,   // tbl_addr presented to the ROM
    S_LOAD,    // ROM word captured into the payload
    S_ISSUE,   // table write in flight
    S_SETTLE,  // post soft-reset wait
    S_NEXT,    // advance table index
    S_DONE,    // idle, serving runtime writes
    S_USR,     // runtime write in flight
    S_ERR      // walk aborted
  } state_e;

  state_e              state_q;
  logic [TBL_AW-1:0]   idx_q;
  logic [TBL_AW-1:0]   tbl_addr_q;
  logic                eng_req_q;
  logic [7:0]          eng_dev_q;
  logic [7:0]          eng_reg_q;
  logic [7:0]          eng_dat_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [RETRY_W-1:0]  retry_q;
  logic                usr_gnt_q;
  logic                usr_done_q;
  logic                usr_err_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [TBL_AW-1:0]   err_index_q;

  logic can_retry;
  logic soft_reset;

  // A NACK may be retried only with the feature built in and attempts left.
  assign can_retry  = RETRY_EN && (retry_q < RETRY_LIMIT);
  // COM7 write with the reset bit set needs the sensor to settle afterwards.
  assign soft_reset = HAS_SETTLE && (eng_reg_q == 8'h12) && eng_dat_q[7];

  // Sequencer FSM; every output is a register updated together with the state.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, exactly like the flops being modelled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      idx_q       <= '0;
      tbl_addr_q  <= '0;
      eng_req_q   <= 1'b0;
      eng_dev_q   <= '0;
      eng_reg_q   <= '0;
      eng_dat_q   <= '0;
      settle_q    <= '0;
      retry_q     <= '0;
      usr_gnt_q   <= 1'b0;
      usr_done_q  <= 1'b0;
      usr_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      eng_dev_q  <= DEV_ADDR;
      usr_gnt_q  <= 1'b0;
      usr_done_q <= 1'b0;
      usr_err_q  <= 1'b0;
      busy_q     <= 1'b1;

      unique case (state_q)
        S_FETCH: state_q <= S_LOAD;

        S_LOAD: begin
          eng_reg_q <= tbl_data_i[15:8];
          eng_dat_q <= tbl_data_i[7:0];
          retry_q   <= '0;
          eng_req_q <= 1'b1;
          state_q   <= S_ISSUE;
        end

        S_ISSUE: begin
          if (!eng_req_q) begin
            eng_req_q <= 1'b1;                 // re-issue after a NACK gap
          end else if (eng.eng_done) begin
            eng_req_q <= 1'b0;
            if (!eng.eng_nack) begin
              settle_q <= '0;
              state_q  <= soft_reset ? S_SETTLE : S_NEXT;
            end else if (can_retry) begin
              retry_q  <= retry_q + 1'b1;
            end else begin
              error_q     <= 1'b1;
              err_index_q <= idx_q;
              busy_q      <= 1'b0;
              state_q     <= S_ERR;
            end
          end
        end

        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_q  <= S_NEXT;
          else                         settle_q <= settle_q + 1'b1;
        end

        S_NEXT: begin
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idx_q      <= idx_q + 1'b1;
            tbl_addr_q <= idx_q + 1'b1;        // ROM sees it during FETCH
            state_q    <= S_FETCH;
          end
        end

        S_DONE: begin
          if (start_i) begin                   // start outranks a pending usr_req
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            idx_q       <= '0;
            tbl_addr_q  <= '0;
            state_q     <= S_FETCH;
          end else if (usr_req_i) begin
            usr_gnt_q <= 1'b1;
            eng_reg_q <= usr_reg_i;
            eng_dat_q <= usr_dat_i;
            retry_q   <= '0;
            state_q   <= S_USR;                // eng_req rises one cycle later
          end else begin
            busy_q <= 1'b0;
          end
        end

        S_USR: begin
          if (!eng_req_q) begin
            eng_req_q <= 1'b1;
          end else if (eng.eng_done) begin
            eng_req_q <= 1'b0;
            if (eng.eng_nack && can_retry) begin
              retry_q <= retry_q + 1'b1;
            end else begin
              usr_done_q <= 1'b1;
              usr_err_q  <= eng.eng_nack;
              busy_q     <= 1'b0;
              state_q    <= S_DONE;
            end
          end
        end

        S_ERR: begin
          if (start_i) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            idx_q       <= '0;
            tbl_addr_q  <= '0;
            state_q     <= S_FETCH;
          end else begin
            busy_q <= 1'b0;
          end
        end

        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign tbl_addr_o   = tbl_addr_q;
  assign eng.eng_req  = eng_req_q;
  assign eng.eng_dev  = eng_dev_q;
  assign eng.eng_reg  = eng_reg_q;
  assign eng.eng_dat  = eng_dat_q;
  assign usr_gnt_o    = usr_gnt_q;
  assign usr_done_o   = usr_done_q;
  assign usr_err_o    = usr_err_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign err_index_o  = err_index_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Self-checking bench for sccb_init_sequencer: synchronous ROM holding the
// OV7670 boot table, a behavioural SCCB engine that acks 10 cycles after each
// request (with programmable NACKs), and directed scenario tasks.
module tb_sccb_init_sequencer;
  localparam int NUM_REGS       = 5;
  localparam int TBL_AW         = 4;
  localparam int RESET_WAIT_CYC = 100;
  localparam int MAX_RETRY      = 3;
  localparam int ACK_DLY        = 10;
`ifdef SCCB_RETRY_EN
  localparam int EXP_ATTEMPTS   = MAX_RETRY + 1;
`else
  localparam int EXP_ATTEMPTS   = 1;
`endif

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b0;
  logic              start    = 1'b0;
  logic [TBL_AW-1:0] tbl_addr;
  logic [15:0]       tbl_data = '0;
  logic              usr_req  = 1'b0;
  logic [7:0]        usr_reg  = '0;
  logic [7:0]        usr_dat  = '0;
  logic              usr_gnt, usr_done, usr_err, busy, done, error;
  logic [TBL_AW-1:0] err_index;

  sccb_init_sequencer_if eng();

  sccb_init_sequencer #(
    .NUM_REGS(NUM_REGS), .TBL_AW(TBL_AW), .DEV_ADDR(8'h42),
    .RESET_WAIT_CYC(RESET_WAIT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start),
    .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data), .eng(eng.master),
    .usr_req_i(usr_req), .usr_reg_i(usr_reg), .usr_dat_i(usr_dat),
    .usr_gnt_o(usr_gnt), .usr_done_o(usr_done), .usr_err_o(usr_err),
    .busy_o(busy), .done_o(done), .error_o(error), .err_index_o(err_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_tbl [NUM_REGS] = '{16'h1280, 16'h1214, 16'h1101, 16'h6B4A, 16'h0C04};

  // Synchronous ROM: word valid the cycle after the address.
  always @(posedge clk) begin
    case (tbl_addr)
      4'd0:    tbl_data <= 16'h1280;
      4'd1:    tbl_data <= 16'h1214;
      4'd2:    tbl_data <= 16'h1101;
      4'd3:    tbl_data <= 16'h6B4A;
      4'd4:    tbl_data <= 16'h0C04;
      default: tbl_data <= 16'h0000;
    endcase
  end

  // Engine model and transaction log (acts on the falling edge).
  int          req_age    = 0;
  bit          served     = 1'b0;
  bit          nack_armed = 1'b0;
  logic [7:0]  nack_reg   = 8'h00;
  int          nack_left  = 0;        // -1: NACK forever
  logic        req_prev   = 1'b0;
  logic [23:0] pay_at_rise = '0;
  bit          unstable   = 1'b0;
  int          rise_cyc[$];
  logic [23:0] rise_pay[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    logic nk;
    eng.eng_done = 1'b0;
    eng.eng_nack = 1'b0;
    if (eng.eng_req && !req_prev) begin
      pay_at_rise = {eng.eng_dev, eng.eng_reg, eng.eng_dat};
      rise_cyc.push_back(cyc);
      rise_pay.push_back(pay_at_rise);
    end
    if (eng.eng_req && ({eng.eng_dev, eng.eng_reg, eng.eng_dat} !== pay_at_rise)) unstable = 1'b1;
    req_prev = eng.eng_req;
    if (!eng.eng_req) begin
      req_age = 0;
      served  = 1'b0;
    end else if (!served) begin
      req_age++;
      if (req_age == ACK_DLY + 1) begin
        nk = nack_armed && (eng.eng_reg == nack_reg) && (nack_left != 0);
        if (nk && nack_left > 0) nack_left--;
        eng.eng_done = 1'b1;
        eng.eng_nack = nk;
        served       = 1'b1;
        done_cyc.push_back(cyc);
      end
    end
  end

  // Runtime-port / status monitor.
  int   gnt_cyc = -1, gnt_count = 0, udone_cyc = -1, done_rise_cyc = -1;
  bit   udone_err = 1'b0, early_gnt = 1'b0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (usr_gnt) begin
      gnt_cyc = cyc;
      gnt_count++;
      if (!done) early_gnt = 1'b1;
    end
    if (usr_done) begin
      udone_cyc = cyc;
      udone_err = usr_err;
    end
    if (done && !done_prev) done_rise_cyc = cyc;
    done_prev = done;
  end

  int rel_cyc   = 0;
  int start_cyc = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    rise_cyc.delete(); rise_pay.delete(); done_cyc.delete();
    unstable = 1'b0; early_gnt = 1'b0; gnt_count = 0;
    gnt_cyc = -1; udone_cyc = -1; done_rise_cyc = -1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_end(input int budget, output bit timed_out);
    int k = 0;
    while (!(done || error) && k < budget) begin tick(); k++; end
    timed_out = !(done || error);
  endtask

  // Serves the runtime handshake: drops usr_req on grant, stops at usr_done.
  task automatic serve_usr(input int budget, output bit timed_out);
    int k = 0;
    while (udone_cyc < 0 && k < budget) begin
      tick();
      if (usr_gnt) usr_req = 1'b0;
      k++;
    end
    timed_out = (udone_cyc < 0);
  endtask

  function automatic int count_pay(input logic [23:0] p);
    int n = 0;
    foreach (rise_pay[i]) if (rise_pay[i] == p) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (tbl_addr !== '0) begin n_bad++; $display("FAIL reset_tbl_addr: got %0h want 0", tbl_addr); end
    n_cmp++; if (eng.eng_req !== 1'b0) begin n_bad++; $display("FAIL reset_eng_req: got %b want 0", eng.eng_req); end
    n_cmp++; if ({eng.eng_dev, eng.eng_reg, eng.eng_dat} !== 24'h0) begin
      n_bad++; $display("FAIL reset_payload: got %h want 000000", {eng.eng_dev, eng.eng_reg, eng.eng_dat}); end
    n_cmp++; if ({usr_gnt, usr_done, usr_err, busy, done, error} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {usr_gnt, usr_done, usr_err, busy, done, error}); end
    n_cmp++; if (err_index !== '0) begin n_bad++; $display("FAIL reset_err_index: got %0d want 0", err_index); end
  endtask

  task automatic test_boot();
    bit to;
    int k = 0;
    clear_log();
    release_reset();
    while (rise_cyc.size() == 0 && k < 20) begin tick(); k++; end
    usr_req = 1'b1; usr_reg = 8'h13; usr_dat = 8'hE7;   // pending through the walk
    wait_end(3000, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL boot_timeout: got done=%b error=%b want done=1", done, error); end
    // Release cycle is FETCH, then LOAD, then ISSUE: req in the third cycle.
    n_cmp++; if (rise_cyc.size() < 1 || rise_cyc[0] - rel_cyc != 2) begin
      n_bad++; $display("FAIL boot_first_req_latency: got %0d want 2", (rise_cyc.size() > 0) ? rise_cyc[0] - rel_cyc : -1); end
    n_cmp++; if (rise_cyc.size() != NUM_REGS) begin
      n_bad++; $display("FAIL boot_txn_count: got %0d want %0d", rise_cyc.size(), NUM_REGS); end
    for (int i = 0; i < NUM_REGS && i < rise_pay.size(); i++) begin
      n_cmp++; if (rise_pay[i] !== {8'h42, exp_tbl[i]}) begin
        n_bad++; $display("FAIL boot_payload_%0d: got %h want %h", i, rise_pay[i], {8'h42, exp_tbl[i]}); end
    end
    for (int i = 0; i < NUM_REGS - 1 && i + 1 < rise_cyc.size() && i < done_cyc.size(); i++) begin
      int want;
      want = (i == 0) ? 4 + RESET_WAIT_CYC : 4;
      n_cmp++; if (rise_cyc[i+1] - done_cyc[i] != want) begin
        n_bad++; $display("FAIL boot_gap_%0d: got %0d want %0d", i, rise_cyc[i+1] - done_cyc[i], want); end
    end
    n_cmp++; if (done_cyc.size() != NUM_REGS || done_rise_cyc - done_cyc[NUM_REGS-1] != 2) begin
      n_bad++; $display("FAIL boot_done_latency: got %0d want 2", done_rise_cyc - ((done_cyc.size() > 0) ? done_cyc[done_cyc.size()-1] : 0)); end
    n_cmp++; if ({done, busy, error} !== 3'b100) begin
      n_bad++; $display("FAIL boot_final_flags: got done/busy/error=%b want 100", {done, busy, error}); end
    n_cmp++; if (unstable) begin n_bad++; $display("FAIL boot_payload_stable: got unstable=1 want 0"); end
  endtask

  task automatic test_usr_pending();
    bit to;
    serve_usr(200, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL usr_timeout: got no usr_done want usr_done"); end
    n_cmp++; if (early_gnt) begin n_bad++; $display("FAIL usr_early_gnt: got grant while done=0 want none"); end
    n_cmp++; if (gnt_count != 1 || gnt_cyc - done_rise_cyc != 1) begin
      n_bad++; $display("FAIL usr_gnt_timing: got count=%0d offset=%0d want count=1 offset=1", gnt_count, gnt_cyc - done_rise_cyc); end
    n_cmp++; if (rise_cyc.size() != NUM_REGS + 1 || rise_cyc[NUM_REGS] - gnt_cyc != 1) begin
      n_bad++; $display("FAIL usr_req_timing: got txns=%0d want %0d with req 1 cycle after gnt", rise_cyc.size(), NUM_REGS + 1); end
    n_cmp++; if (rise_pay.size() != NUM_REGS + 1 || rise_pay[NUM_REGS] !== 24'h4213E7) begin
      n_bad++; $display("FAIL usr_payload: got %h want 4213e7", (rise_pay.size() > NUM_REGS) ? rise_pay[NUM_REGS] : 24'h0); end
    n_cmp++; if (done_cyc.size() != NUM_REGS + 1 || udone_cyc - done_cyc[NUM_REGS] != 1 || udone_err !== 1'b0) begin
      n_bad++; $display("FAIL usr_done: got offset=%0d err=%b want offset=1 err=0", udone_cyc - ((done_cyc.size() > 0) ? done_cyc[done_cyc.size()-1] : 0), udone_err); end
  endtask

  task automatic test_nack_abort();
    bit to;
    clear_log();
    nack_armed = 1'b1; nack_reg = 8'h11; nack_left = -1;
    pulse_start();
    wait_end(3000, to);
    n_cmp++; if (to || {error, done, busy} !== 3'b100) begin
      n_bad++; $display("FAIL nack_flags: got error/done/busy=%b want 100", {error, done, busy}); end
    n_cmp++; if (err_index !== 4'd2) begin n_bad++; $display("FAIL nack_err_index: got %0d want 2", err_index); end
    n_cmp++; if (count_pay(24'h421101) != EXP_ATTEMPTS || rise_pay.size() != 2 + EXP_ATTEMPTS) begin
      n_bad++; $display("FAIL nack_attempts: got %0d of %0d txns want %0d", count_pay(24'h421101), rise_pay.size(), EXP_ATTEMPTS); end
`ifdef SCCB_RETRY_EN
    n_cmp++; if (rise_cyc.size() < 4 || done_cyc.size() < 3 || rise_cyc[3] - done_cyc[2] != 2) begin
      n_bad++; $display("FAIL retry_gap: got bad re-issue spacing want 2"); end
`endif
    nack_armed = 1'b0;
  endtask

  task automatic test_restart_from_err();
    bit to;
    clear_log();
    pulse_start();
    n_cmp++; if ({error, err_index} !== 5'b0) begin
      n_bad++; $display("FAIL restart_clear: got error=%b err_index=%0d want 0/0", error, err_index); end
    wait_end(3000, to);
    n_cmp++; if (to || rise_pay.size() != NUM_REGS || rise_cyc[0] - start_cyc != 3 || rise_pay[0] !== 24'h421280) begin
      n_bad++; $display("FAIL restart_walk: got txns=%0d want %0d from entry 0, 3 cycles after start", rise_pay.size(), NUM_REGS); end
    n_cmp++; if ({done, error} !== 2'b10) begin n_bad++; $display("FAIL restart_done: got done/error=%b want 10", {done, error}); end
  endtask

`ifdef SCCB_RETRY_EN
  task automatic test_retry_recover();
    bit to;
    clear_log();
    nack_armed = 1'b1; nack_reg = 8'h11; nack_left = 2;
    pulse_start();
    wait_end(3000, to);
    n_cmp++; if (to || count_pay(24'h421101) != 3 || rise_pay.size() != NUM_REGS + 2) begin
      n_bad++; $display("FAIL retry_recover_count: got %0d want 3", count_pay(24'h421101)); end
    n_cmp++; if ({done, error} !== 2'b10) begin n_bad++; $display("FAIL retry_recover_flags: got done/error=%b want 10", {done, error}); end
    nack_armed = 1'b0;
  endtask
`endif

  task automatic test_usr_nack();
    bit to;
    clear_log();
    nack_armed = 1'b1; nack_reg = 8'h13; nack_left = -1;
    @(negedge clk);
    usr_req = 1'b1; usr_reg = 8'h13; usr_dat = 8'h55;
    serve_usr(300, to);
    n_cmp++; if (to || udone_err !== 1'b1) begin n_bad++; $display("FAIL usr_nack_err: got %b want 1", udone_err); end
    n_cmp++; if (count_pay(24'h421355) != EXP_ATTEMPTS) begin
      n_bad++; $display("FAIL usr_nack_attempts: got %0d want %0d", count_pay(24'h421355), EXP_ATTEMPTS); end
    tick();
    n_cmp++; if ({done, error, busy} !== 3'b100) begin
      n_bad++; $display("FAIL usr_nack_flags: got done/error/busy=%b want 100", {done, error, busy}); end
    nack_armed = 1'b0;
  endtask

  task automatic test_start_vs_usr();
    bit to;
    clear_log();
    @(negedge clk);
    start = 1'b1; usr_req = 1'b1; usr_reg = 8'h14; usr_dat = 8'h21;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_cmp++; if ({usr_gnt, done, busy} !== 3'b001) begin
      n_bad++; $display("FAIL start_wins: got gnt/done/busy=%b want 001", {usr_gnt, done, busy}); end
    wait_end(3000, to);
    serve_usr(100, to);
    n_cmp++; if (to || early_gnt || rise_pay.size() != NUM_REGS + 1 || rise_pay[NUM_REGS] !== 24'h421421) begin
      n_bad++; $display("FAIL start_vs_usr_order: got early_gnt=%b txns=%0d want 0/%0d ending 421421", early_gnt, rise_pay.size(), NUM_REGS + 1); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int k = 0;
    clear_log();
    pulse_start();
    while (rise_cyc.size() < 4 && k < 1000) begin tick(); k++; end
    n_cmp++; if (eng.eng_req !== 1'b1 || rise_pay.size() != 4 || rise_pay[3] !== 24'h426B4A) begin
      n_bad++; $display("FAIL mid_precondition: got req=%b txns=%0d want req=1 on entry 3", eng.eng_req, rise_pay.size()); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({eng.eng_req, tbl_addr, busy, done, error, usr_gnt, usr_done, usr_err} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got req=%b addr=%0d busy=%b want all 0", eng.eng_req, tbl_addr, busy); end
    n_cmp++; if ({eng.eng_dev, eng.eng_reg, eng.eng_dat, err_index} !== '0) begin
      n_bad++; $display("FAIL mid_reset_payload: got %h want 0", {eng.eng_dev, eng.eng_reg, eng.eng_dat}); end
    repeat (2) tick();
    release_reset();
    k = 0;
    while (rise_cyc.size() < 5 && k < 20) begin tick(); k++; end
    n_cmp++; if (rise_cyc.size() < 5 || rise_cyc[4] - rel_cyc != 2 || rise_pay[4] !== 24'h421280) begin
      n_bad++; $display("FAIL mid_reissue_entry0: got txns=%0d want entry 0 in third cycle after release", rise_cyc.size()); end
    wait_end(3000, to);
    n_cmp++; if (to || {done, error} !== 2'b10 || rise_pay.size() != 4 + NUM_REGS) begin
      n_bad++; $display("FAIL mid_rewalk: got done/error=%b txns=%0d want 10/%0d", {done, error}, rise_pay.size(), 4 + NUM_REGS); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_usr_pending();
    test_nack_abort();
    test_restart_from_err();
`ifdef SCCB_RETRY_EN
    test_retry_recover();
`endif
    test_usr_nack();
    test_start_vs_usr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sccb_init_sequencer.md
# sccb_init_sequencer

Sequences the OV7670 camera's SCCB register programming. After reset it walks a register table and issues one device write per entry to the SCCB transaction engine over a req/done handshake. It inserts a settle delay after any soft-reset write. Once the table is complete, it grants the same engine to a runtime write port used by the arm controller for exposure and gain tweaks.

## Interface
- NUM_REGS, 5: number of table entries, 1..2^TBL_AW
- TBL_AW, 4: table address width
- DEV_ADDR, 8'h42: SCCB write address driven on every transaction
- RESET_WAIT_CYC, 50000: clk cycles of settle time after a soft-reset write (1 ms at 50 MHz)
- MAX_RETRY, 3: extra attempts per write after NACK (used only with SCCB_RETRY_EN)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; restarts the table walk from entry 0
- tbl_addr  out  TBL_AW  table read address
- tbl_data  in  16  {reg, data}; synchronous ROM, valid 1 cycle after tbl_addr
- eng_req  out  1  transaction request to the SCCB engine
- eng_dev / eng_reg / eng_dat  out  8 each  transaction payload
- eng_done  in  1  1-cycle pulse, transaction finished
- eng_nack  in  1  qualified by eng_done; 1 = slave did not acknowledge
- usr_req  in  1  runtime write request (level)
- usr_reg / usr_dat  in  8 each  runtime payload, held stable while usr_req=1
- usr_gnt  out  1  1-cycle pulse, runtime payload captured
- usr_done  out  1  1-cycle pulse, runtime write finished
- usr_err  out  1  valid with usr_done; write failed
- busy  out  1  a table walk or runtime write is in progress
- done  out  1  table fully written
- error  out  1  table walk aborted
- err_index  out  TBL_AW  index of the failing entry

## Operation
- States and transitions:
  - FETCH: drive tbl_addr = idx.
  - LOAD: capture tbl_data into eng_reg and eng_dat.
  - ISSUE: hold eng_req until eng_done.
  - SETTLE: count RESET_WAIT_CYC cycles.
  - NEXT: advance idx.
  - DONE: idle, serving runtime writes.
  - USR: runtime write in flight.
  - ERR: walk aborted.
- Reset release enters FETCH with idx=0. No start pulse is needed for boot.
- ISSUE result handling:
  - eng_done with eng_nack=0 goes to SETTLE when eng_reg==8'h12 and eng_dat[7]==1; otherwise it goes to NEXT.
  - eng_done with eng_nack=1 is handled under Configuration.
- NEXT: if idx==NUM_REGS-1, go to DONE and set done=1. Otherwise idx+1, then FETCH.
- DONE with usr_req=1: pulse usr_gnt, capture usr_reg and usr_dat, go to USR (same ISSUE handshake). On eng_done: pulse usr_done, with usr_err=eng_nack after any retries, then return to DONE.
- usr_req outside DONE is held off with no usr_gnt. The bench must see no grant until done=1.
- start is accepted only in DONE or ERR. It clears done, error and err_index, sets idx=0, and goes to FETCH. start is ignored in every other state.
- start and usr_req asserted together in DONE: start wins and usr_req stays pending.
- eng_dev always equals DEV_ADDR.
- busy = state is not DONE and not ERR.

## Timing
- Reset values: every output 0, tbl_addr=0, idx=0. Assertion of reset_n mid-transaction drops eng_req asynchronously, and the engine must abort.
- First eng_req rises 3 cycles after reset release: FETCH, LOAD, ISSUE.
- eng_req and the payload are registered and stay stable from rise until the cycle eng_done is sampled. eng_req is low the following cycle.
- Inter-entry gap (eng_done to next eng_req): 4 cycles (NEXT, FETCH, LOAD, ISSUE). SETTLE adds exactly RESET_WAIT_CYC cycles.
- Runtime write: usr_gnt is the cycle after usr_req is sampled in DONE. eng_req follows 1 cycle later. usr_done is 1 cycle after eng_done.
- The retry counter is wide enough for MAX_RETRY and never wraps. idx never exceeds NUM_REGS-1.

## Configuration
- SCCB_RETRY_EN defined:
  - On NACK, eng_req drops for 1 cycle and the same payload is re-issued, up to MAX_RETRY more times.
  - The retry counter clears on each new entry or runtime write.
  - When retries are exhausted: a table walk goes to ERR with error=1 and err_index=idx; a runtime write returns usr_err=1.
- SCCB_RETRY_EN undefined:
  - The first NACK goes straight to ERR, or returns usr_err=1 for a runtime write.
  - MAX_RETRY is ignored.

## Test plan
- Boot table {12/80, 12/14, 11/01, 6B/4A, 0C/04}, engine acks 10 cycles after req -> 5 transactions in order with eng_dev=0x42, then done=1, busy=0, error=0.
- Same table with RESET_WAIT_CYC=100 -> the second eng_req rises exactly 104 cycles after the first eng_done. All other gaps are 4 cycles.
- SCCB_RETRY_EN, entry 2 NACKs twice then acks -> three identical 11/01 requests, then done=1, error=0.
- SCCB_RETRY_EN, entry 2 always NACKs -> four attempts, then error=1, err_index=2, done=0. A start pulse then reruns from entry 0.
- usr_req {13/E7} raised during boot -> no usr_gnt before done=1. The write issues afterwards; usr_done=1 with usr_err=0.
- reset_n asserted while eng_req=1 on entry 3 -> all outputs 0 immediately. After release, entry 0 is reissued at cycle 3.
